// File: rtl/mult_pkg.sv
// Shared types and constants for the HI/LO multiply sequencer.
package mult_pkg;
    localparam int HILO_W      = 32;
    localparam int PROD_W      = 2 * HILO_W;
    localparam int DEF_TIMEOUT = 40;
    localparam int DEF_CNT_W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// Issue-stage request, multiplier link and HI/LO access signals of the sequencer.
interface mult_hilo_ctrl_if;
    import mult_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [HILO_W-1:0] req_op1;
    logic [HILO_W-1:0] req_op2;
    logic              mult_begin;
    logic [HILO_W-1:0] mult_op1;
    logic [HILO_W-1:0] mult_op2;
    logic [PROD_W-1:0] product;
    logic              mult_end;
    logic              hi_we;
    logic              lo_we;
    logic [HILO_W-1:0] wdata;
    logic [HILO_W-1:0] hi;
    logic [HILO_W-1:0] lo;
    logic              busy;
    logic              res_valid;
    logic              wr_err;
    logic              timeout;

    modport slave (
        input  req_valid, req_op1, req_op2, product, mult_end, hi_we, lo_we, wdata,
        output req_ready, mult_begin, mult_op1, mult_op2, hi, lo, busy,
               res_valid, wr_err, timeout
    );

    modport master (
        output req_valid, req_op1, req_op2, product, mult_end, hi_we, lo_we, wdata,
        input  req_ready, mult_begin, mult_op1, mult_op2, hi, lo, busy,
               res_valid, wr_err, timeout
    );
endinterface

// File: rtl/mult_hilo_ctrl_hilo_regs.sv
// Architectural HI/LO pair: multiply result write, direct writes, and drop
// reporting for direct writes that collide with an operation in flight.
module hilo_regs
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mul_we,
    input  logic [PROD_W-1:0] product,
    input  logic              drop,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [HILO_W-1:0] wdata,
    output logic [HILO_W-1:0] hi,
    output logic [HILO_W-1:0] lo,
    output logic              wr_err
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= drop && (hi_we || lo_we);
            if (mul_we) begin
                hi <= product[PROD_W-1:HILO_W];
                lo <= product[HILO_W-1:0];
            end
            // Direct writes take priority; they can only coincide with a
            // multiply write if the caller lets them through while busy.
            if (!drop && hi_we) hi <= wdata;
            if (!drop && lo_we) lo <= wdata;
        end
    end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequencer between the issue stage and the Booth multiplier: request capture,
// hold-high start protocol, watchdog abort and HI/LO result capture.
//
//   state | meaning
//   IDLE  | ready for a request; direct HI/LO writes allowed
//   BUSY  | mult_begin held high, waiting for mult_end or watchdog expiry
//   DONE  | one cycle with mult_begin low so the multiplier clears; writes allowed
module mult_hilo_ctrl
    import mult_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
)
(
    input  logic             clk,
    input  logic             rst,
    mult_hilo_ctrl_if.slave  bus
);

    if (TIMEOUT < 18 || (2 ** CNT_W) <= TIMEOUT) begin : g_bad_param
        $error("mult_hilo_ctrl: TIMEOUT must be >= 18 and below 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [HILO_W-1:0] op1_q;
    logic [HILO_W-1:0] op2_q;
    logic              begin_q;
    logic              res_q;
    logic              to_q;
    logic              mul_we;
    logic              expire;
    logic              ready;
    logic              in_busy;

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        in_busy   = 1'b0;
        mul_we    = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) state_nxt = BUSY;
            end
            BUSY: begin
                in_busy = 1'b1;
                if (bus.mult_end) begin
                    mul_we    = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            begin_q <= 1'b0;
            res_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            // mult_begin comes straight from a flop so the multiplier never sees a glitch
            begin_q <= (state_nxt == BUSY);
            res_q   <= mul_we;
            to_q    <= expire;
            if (state == IDLE && bus.req_valid) begin
                op1_q <= bus.req_op1;
                op2_q <= bus.req_op2;
                cnt   <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    hilo_regs u_hilo_regs (
        .clk     (clk),
        .rst     (rst),
        .mul_we  (mul_we),
        .product (bus.product),
        .drop    (in_busy),
        .hi_we   (bus.hi_we),
        .lo_we   (bus.lo_we),
        .wdata   (bus.wdata),
        .hi      (bus.hi),
        .lo      (bus.lo),
        .wr_err  (bus.wr_err)
    );

    assign bus.req_ready  = ready;
    assign bus.busy       = in_busy;
    assign bus.mult_begin = begin_q;
    assign bus.mult_op1   = op1_q;
    assign bus.mult_op2   = op2_q;
    assign bus.res_valid  = res_q;
    assign bus.timeout    = to_q;

endmodule
